// File: rtl/autoconfig_chain.sv
// Purpose: Zorro II autoconfig responder presenting NUM_BOARDS logical boards in turn behind one CFGIN_n/CFGOUT_n pair.
// Latency: dtack and the read/write action land 1 CLK after UDS_n falls inside an autoconfig cycle; board_hit/autoconfig_cycle are combinational.
// Backpressure: none; dtack is held until AS_n rises, and only one action is taken per bus cycle.
//
// Ports:
//   CLK, RESET (sync, active-high)
//   ADDR[23:1], AS_n, UDS_n, RW, DIN[3:0]    : Zorro bus side (strobes sampled on CLK)
//   CFGIN_n / CFGOUT_n                         : autoconfig chain in / out
//   board_enable[NUM_BOARDS-1:0]               : boards taking part in the chain
//   autoconfig_cycle, DOUT[3:0], dtack         : responder outputs
//   board_configured, board_base, board_hit    : per-board results for downstream decode
//   rom_hit                                    : only with AUTOCONFIG_ROM_EN defined
// Build option: define AUTOCONFIG_ROM_EN to give board 0 a diag ROM (rom bit, ROM vector, rom_hit).
module autoconfig_chain #(
    parameter int                       NUM_BOARDS   = 2,
    parameter logic [15:0]              MFG_ID       = 16'd5194,
    parameter logic [7:0]               PROD_ID_BASE = 8'd6,
    parameter logic [31:0]              SERIAL       = 32'd1,
    parameter logic [3*NUM_BOARDS-1:0]  SIZE_CODES   = {3'b010, 3'b010},
    parameter logic [15:0]              ROM_VECTOR   = 16'h0008
) (
    input  logic                        CLK,
    input  logic                        RESET,
    input  logic [23:1]                 ADDR,
    input  logic                        AS_n,
    input  logic                        UDS_n,
    input  logic                        RW,
    input  logic [3:0]                  DIN,
    input  logic                        CFGIN_n,
    input  logic [NUM_BOARDS-1:0]       board_enable,
    output logic                        CFGOUT_n,
    output logic                        autoconfig_cycle,
    output logic [3:0]                  DOUT,
    output logic                        dtack,
    output logic [NUM_BOARDS-1:0]       board_configured,
    output logic [8*NUM_BOARDS-1:0]     board_base,
    output logic [NUM_BOARDS-1:0]       board_hit
`ifdef AUTOCONFIG_ROM_EN
    ,
    output logic                        rom_hit
`endif
);

    localparam int CW = (NUM_BOARDS > 1) ? $clog2(NUM_BOARDS) : 1;

    typedef enum logic [1:0] {WAIT_CFG, PRESENT, DONE} state_t;

    state_t                     r_state;
    logic [CW-1:0]              r_cur;
    logic                       r_cfgin;
    logic                       r_as_q;
    logic                       r_advance;
    logic                       r_dtack;
    logic [3:0]                 r_dout;
    logic [3:0]                 r_pending_lo;
    logic                       r_cfgout_n;
    logic [NUM_BOARDS-1:0]      r_configured;
    logic [8*NUM_BOARDS-1:0]    r_base;

    logic                       w_eoc;
    logic                       w_ac_cycle;
    logic                       w_first_vld;
    logic [CW-1:0]              w_first_idx;
    logic                       w_next_vld;
    logic [CW-1:0]              w_next_idx;
    logic [7:0]                 w_prod;
    logic [2:0]                 w_size;
    logic                       w_rom;
    logic [3:0]                 w_rd_nib;
    logic [7:0]                 w_mask;
    logic [NUM_BOARDS-1:0]      w_hit;
    logic                       w_unused;

    // End of a bus cycle: AS_n was low last CLK and is high now.
    assign w_eoc      = !r_as_q && AS_n;
    assign w_ac_cycle = (ADDR[23:16] == 8'hE8) && r_cfgin && (r_state == PRESENT) && !AS_n;
    assign w_prod     = PROD_ID_BASE + 8'(r_cur);
    assign w_size     = SIZE_CODES[r_cur*3 +: 3];
    assign w_unused   = ^{ADDR[15:9], ROM_VECTOR};

`ifdef AUTOCONFIG_ROM_EN
    assign w_rom   = (r_cur == '0);
    assign rom_hit = w_hit[0] && (ADDR[15:1] < 15'h4000);
`else
    assign w_rom   = 1'b0;
`endif

    // Lowest enabled board overall, and lowest enabled board above r_cur.
    always_comb begin
        w_first_vld = 1'b0;
        w_first_idx = '0;
        w_next_vld  = 1'b0;
        w_next_idx  = '0;
        for (int k = NUM_BOARDS - 1; k >= 0; k--) begin
            if (board_enable[k]) begin
                w_first_vld = 1'b1;
                w_first_idx = CW'(k);
                if (k > int'(r_cur)) begin
                    w_next_vld = 1'b1;
                    w_next_idx = CW'(k);
                end
            end
        end
    end

    // Read map; everything except offsets 0x00/0x01 is returned inverted.
    always_comb begin
        w_rd_nib = 4'hF;
        case (ADDR[8:1])
            8'h00: w_rd_nib = {3'b110, w_rom};
            8'h01: w_rd_nib = {1'b0, w_size};
            8'h02: w_rd_nib = ~w_prod[7:4];
            8'h03: w_rd_nib = ~w_prod[3:0];
            8'h04: w_rd_nib = 4'hF;
            8'h05: w_rd_nib = 4'hF;
            8'h08: w_rd_nib = ~MFG_ID[15:12];
            8'h09: w_rd_nib = ~MFG_ID[11:8];
            8'h0A: w_rd_nib = ~MFG_ID[7:4];
            8'h0B: w_rd_nib = ~MFG_ID[3:0];
            8'h0C: w_rd_nib = ~SERIAL[31:28];
            8'h0D: w_rd_nib = ~SERIAL[27:24];
            8'h0E: w_rd_nib = ~SERIAL[23:20];
            8'h0F: w_rd_nib = ~SERIAL[19:16];
            8'h10: w_rd_nib = ~SERIAL[15:12];
            8'h11: w_rd_nib = ~SERIAL[11:8];
            8'h12: w_rd_nib = ~SERIAL[7:4];
            8'h13: w_rd_nib = ~SERIAL[3:0];
`ifdef AUTOCONFIG_ROM_EN
            8'h14: w_rd_nib = w_rom ? ~ROM_VECTOR[15:12] : 4'hF;
            8'h15: w_rd_nib = w_rom ? ~ROM_VECTOR[11:8]  : 4'hF;
            8'h16: w_rd_nib = w_rom ? ~ROM_VECTOR[7:4]   : 4'hF;
            8'h17: w_rd_nib = w_rom ? ~ROM_VECTOR[3:0]   : 4'hF;
`endif
            8'h20: w_rd_nib = 4'h0;
            8'h21: w_rd_nib = 4'h0;
            default: w_rd_nib = 4'hF;
        endcase
    end

    // Window decode: size code n covers 2^(n-1) 64K units, so the low n-1 base bits are don't-care.
    always_comb begin
        w_mask = 8'hFF;
        w_hit  = '0;
        for (int k = 0; k < NUM_BOARDS; k++) begin
            w_mask   = 8'hFF << (SIZE_CODES[k*3 +: 3] - 3'd1);
            w_hit[k] = r_configured[k] && ((ADDR[23:16] & w_mask) == (r_base[k*8 +: 8] & w_mask));
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state      <= WAIT_CFG;
            r_cur        <= '0;
            r_cfgin      <= 1'b0;
            r_as_q       <= 1'b1;
            r_advance    <= 1'b0;
            r_dtack      <= 1'b0;
            r_dout       <= 4'h0;
            r_pending_lo <= 4'h0;
            r_cfgout_n   <= 1'b1;
            r_configured <= '0;
            r_base       <= '0;
        end else begin
            r_as_q <= AS_n;
            if (w_eoc) begin
                r_cfgin <= !CFGIN_n;
            end

            // !r_dtack limits each bus cycle to a single action.
            if (!UDS_n && w_ac_cycle && !r_dtack) begin
                r_dtack <= 1'b1;
                if (RW) begin
                    r_dout <= w_rd_nib;
                end else begin
                    case (ADDR[8:1])
                        8'h25: r_pending_lo <= DIN;
                        8'h24: begin
                            r_base[r_cur*8 +: 8] <= {DIN, r_pending_lo};
                            r_configured[r_cur]  <= 1'b1;
                            r_advance            <= 1'b1;
                        end
                        8'h26: r_advance <= 1'b1;
                        default: ;
                    endcase
                end
            end else if (AS_n) begin
                r_dtack <= 1'b0;
            end

            // Advance only takes effect at the end of the bus cycle that requested it.
            case (r_state)
                WAIT_CFG: begin
                    if (r_cfgin) begin
                        if (w_first_vld) begin
                            r_state <= PRESENT;
                            r_cur   <= w_first_idx;
                        end else begin
                            r_state    <= DONE;
                            r_cfgout_n <= 1'b0;
                        end
                    end
                end
                PRESENT: begin
                    if (w_eoc && r_advance) begin
                        r_advance <= 1'b0;
                        if (w_next_vld) begin
                            r_cur <= w_next_idx;
                        end else begin
                            r_state    <= DONE;
                            r_cfgout_n <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign CFGOUT_n         = r_cfgout_n;
    assign autoconfig_cycle = w_ac_cycle;
    assign DOUT             = r_dout;
    assign dtack            = r_dtack;
    assign board_configured = r_configured;
    assign board_base       = r_base;
    assign board_hit        = w_hit;

endmodule

// File: tb/tb_autoconfig_chain.sv
// Purpose: directed self-checking bench for autoconfig_chain (default build, two 128K boards).
// Latency: expects dtack one CLK after UDS_n falls inside an autoconfig cycle.
// Backpressure: bus cycles are bounded to 4 CLKs waiting for dtack.
module tb_autoconfig_chain;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [23:1] ADDR;
    logic        AS_n;
    logic        UDS_n;
    logic        RW;
    logic [3:0]  DIN;
    logic        CFGIN_n;
    logic [1:0]  board_enable;
    logic        CFGOUT_n;
    logic        autoconfig_cycle;
    logic [3:0]  DOUT;
    logic        dtack;
    logic [1:0]  board_configured;
    logic [15:0] board_base;
    logic [1:0]  board_hit;
`ifdef AUTOCONFIG_ROM_EN
    logic        rom_hit;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [3:0] rd;
    int         lat;
    logic       ac;

    autoconfig_chain dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .ADDR             (ADDR),
        .AS_n             (AS_n),
        .UDS_n            (UDS_n),
        .RW               (RW),
        .DIN              (DIN),
        .CFGIN_n          (CFGIN_n),
        .board_enable     (board_enable),
        .CFGOUT_n         (CFGOUT_n),
        .autoconfig_cycle (autoconfig_cycle),
        .DOUT             (DOUT),
        .dtack            (dtack),
        .board_configured (board_configured),
        .board_base       (board_base),
        .board_hit        (board_hit)
`ifdef AUTOCONFIG_ROM_EN
        ,
        .rom_hit          (rom_hit)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    // One full bus cycle starting at posedge+1; returns dtack latency (0 = never acked).
    task automatic bus_cycle(input logic [7:0] hi, input logic [7:0] idx, input logic rw,
                             input logic [3:0] din, output logic [3:0] rd_o,
                             output int lat_o, output logic ac_o);
        ADDR  = {hi, 7'd0, idx};
        RW    = rw;
        DIN   = din;
        AS_n  = 1'b0;
        UDS_n = 1'b0;
        #1;
        ac_o  = autoconfig_cycle;
        lat_o = 0;
        rd_o  = 4'h0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge CLK);
            #1;
            if (dtack) begin
                lat_o = i;
                rd_o  = DOUT;
                break;
            end
        end
        AS_n  = 1'b1;
        UDS_n = 1'b1;
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] idx, input logic [3:0] exp);
        bus_cycle(8'hE8, idx, 1'b1, 4'h0, rd, lat, ac);
        chk({tag, "_lat"}, lat, 1);
        chk(tag, rd, exp);
    endtask

    task automatic wr(input logic [7:0] idx, input logic [3:0] d);
        bus_cycle(8'hE8, idx, 1'b0, d, rd, lat, ac);
        chk("wr_lat", lat, 1);
    endtask

    task automatic hit_chk(input string tag, input logic [7:0] hi, input logic [1:0] exp);
        ADDR = {hi, 15'd0};
        #1;
        chk(tag, board_hit, exp);
    endtask

    // Dummy unacknowledged cycle: its end-of-cycle latches CFGIN_n low.
    task automatic open_chain();
        CFGIN_n = 1'b0;
        bus_cycle(8'hE8, 8'h00, 1'b1, 4'h0, rd, lat, ac);
        chk("open_nodtack", lat, 0);
    endtask

    initial begin
        RESET        = 1'b0;
        ADDR         = '0;
        AS_n         = 1'b1;
        UDS_n        = 1'b1;
        RW           = 1'b1;
        DIN          = 4'h0;
        CFGIN_n      = 1'b1;
        board_enable = 2'b11;
        @(posedge CLK);
        #1;

        // Reset state and a chain that is not yet ours.
        do_reset();
        chk("rst_dtack", dtack, 0);
        chk("rst_cfgout", CFGOUT_n, 1);
        chk("rst_cfg", board_configured, 0);
        chk("rst_base", board_base, 0);
        chk("rst_dout", DOUT, 0);
        bus_cycle(8'hE8, 8'h00, 1'b1, 4'h0, rd, lat, ac);
        chk("closed_ac", ac, 0);
        chk("closed_lat", lat, 0);
        chk("closed_cfgout", CFGOUT_n, 1);

        // Chain opened: board 0 read map.
        open_chain();
        bus_cycle(8'hE8, 8'h02, 1'b1, 4'h0, rd, lat, ac);
        chk("b0_ac", ac, 1);
        chk("b0_r02_lat", lat, 1);
        chk("b0_r02", rd, 4'hF);
        rd_chk("b0_r01", 8'h01, 4'b0010);
        rd_chk("b0_r00", 8'h00, 4'hC);
        rd_chk("b0_r03", 8'h03, 4'h9);
        rd_chk("b0_r05", 8'h05, 4'hF);
        rd_chk("b0_r08", 8'h08, 4'hE);
        rd_chk("b0_r0b", 8'h0B, 4'h5);
        rd_chk("b0_r0c", 8'h0C, 4'hF);
        rd_chk("b0_r13", 8'h13, 4'hE);
        rd_chk("b0_r14", 8'h14, 4'hF);
        rd_chk("b0_r20", 8'h20, 4'h0);
        rd_chk("b0_r30", 8'h30, 4'hF);

        // Configure board 0 at E9, then board 1 at EA.
        wr(8'h25, 4'h9);
        wr(8'h24, 4'hE);
        chk("b0_base", board_base[7:0], 8'hE9);
        chk("b0_cfg", board_configured, 2'b01);
        chk("b0_cfgout", CFGOUT_n, 1);
        rd_chk("b1_r03", 8'h03, 4'h8);
        rd_chk("b1_r01", 8'h01, 4'b0010);
        wr(8'h25, 4'hA);
        wr(8'h24, 4'hE);
        chk("b1_base", board_base[15:8], 8'hEA);
        chk("both_cfg", board_configured, 2'b11);
        chk("done_cfgout", CFGOUT_n, 0);
        bus_cycle(8'hE8, 8'h00, 1'b1, 4'h0, rd, lat, ac);
        chk("done_ac", ac, 0);
        chk("done_lat", lat, 0);
        hit_chk("hit_e8", 8'hE8, 2'b01);
        hit_chk("hit_e9", 8'hE9, 2'b01);
        hit_chk("hit_ea", 8'hEA, 2'b10);
        hit_chk("hit_eb", 8'hEB, 2'b10);
        hit_chk("hit_ec", 8'hEC, 2'b00);

        // Only board 1 enabled.
        CFGIN_n = 1'b1;
        do_reset();
        board_enable = 2'b10;
        open_chain();
        rd_chk("en10_r03", 8'h03, 4'h8);
        wr(8'h25, 4'hA);
        wr(8'h24, 4'hE);
        chk("en10_cfgout", CFGOUT_n, 0);
        chk("en10_cfg", board_configured, 2'b10);

        // Board 0 shut up, board 1 configured.
        CFGIN_n = 1'b1;
        board_enable = 2'b11;
        do_reset();
        open_chain();
        wr(8'h26, 4'h0);
        chk("shut_cfg", board_configured, 2'b00);
        rd_chk("shut_r03", 8'h03, 4'h8);
        wr(8'h25, 4'hA);
        wr(8'h24, 4'hE);
        chk("shut_cfg2", board_configured, 2'b10);
        chk("shut_cfgout", CFGOUT_n, 0);
        hit_chk("shut_hit_eb", 8'hEB, 2'b10);
        hit_chk("shut_hit_e8", 8'hE8, 2'b00);

        // Reset in the middle of an acknowledged read.
        CFGIN_n = 1'b1;
        do_reset();
        open_chain();
        wr(8'h25, 4'h9);
        wr(8'h24, 4'hE);
        ADDR  = {8'hE8, 7'd0, 8'h03};
        RW    = 1'b1;
        AS_n  = 1'b0;
        UDS_n = 1'b0;
        @(posedge CLK);
        #1;
        chk("mid_dtack", dtack, 1);
        chk("mid_dout", DOUT, 4'h8);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        chk("mid_rst_dtack", dtack, 0);
        chk("mid_rst_base", board_base, 0);
        chk("mid_rst_cfg", board_configured, 0);
        chk("mid_rst_cfgout", CFGOUT_n, 1);
        chk("mid_rst_dout", DOUT, 0);
        RESET = 1'b0;
        #1;
        chk("mid_rst_ac", autoconfig_cycle, 0);
        @(posedge CLK);
        #1;
        chk("mid_rst_noack", dtack, 0);
        AS_n  = 1'b1;
        UDS_n = 1'b1;
        @(posedge CLK);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/autoconfig_chain.md
Name: autoconfig_chain

Overview:
- Parametrised successor to the single-board Zorro II autoconfig responder.
- Presents NUM_BOARDS logical boards in sequence behind one physical CFGIN_n/CFGOUT_n pair. Examples: IDE plus a RAM or IO window.
- Each board gets its own ID nibbles, size code and base register, plus a qualified address-hit output. Downstream decode (IDE, RAM, ROM) uses these outputs.
- Fully synchronous to CLK. Bus strobes are sampled, never used as clocks.

Parameters:
- NUM_BOARDS, 2: logical boards presented, 1..4.
- MFG_ID, 16'd5194: manufacturer ID, shared by all boards.
- PROD_ID_BASE, 8'd6: product ID of board k is PROD_ID_BASE+k.
- SERIAL, 32'd1: serial number, shared by all boards.
- SIZE_CODES, {3'b010,3'b010}: packed 3-bit er_Type size per board, board 0 in LSBs. Encodings: 001=64K, 010=128K, 011=256K, 100=512K, 101=1M, 110=2M, 111=4M. 000 (8M) is illegal.
- ROM_VECTOR, 16'h0008: diag ROM offset, returned at 0x14..0x17.

Ports:
- CLK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- ADDR  in  23  bus address [23:1]
- AS_n  in  1  address strobe
- UDS_n  in  1  upper data strobe
- RW  in  1  1=read
- DIN  in  4  write data D[15:12]
- CFGIN_n  in  1  chain input
- board_enable  in  NUM_BOARDS  1=board participates
- CFGOUT_n  out  1  chain output
- autoconfig_cycle  out  1  current access targets autoconfig space and is ours
- DOUT  out  4  read nibble
- dtack  out  1  cycle acknowledge
- board_configured  out  NUM_BOARDS  per-board configured flag
- board_base  out  8*NUM_BOARDS  A23:16 base per board
- board_hit  out  NUM_BOARDS  ADDR inside board k window

Behaviour:
- Reset (synchronous, RESET=1 at CLK edge) clears all of the following:
  - state = WAIT_CFG, cur = 0, cfgin = 0, as_q = 1;
  - DOUT = 0, dtack = 0;
  - board_configured = 0, board_base = 0, pending_lo = 0;
  - CFGOUT_n = 1.
- Reset mid-cycle aborts any cycle. dtack is not held.
- End-of-cycle strobe: eoc = !as_q && AS_n, where as_q is AS_n registered each CLK.
- cfgin is updated only at eoc: cfgin <= !CFGIN_n.
- States:
  - WAIT_CFG: leave when cfgin=1. Go to PRESENT with cur = lowest enabled board. If no board is enabled, go to DONE.
  - PRESENT: answer for board cur.
  - DONE: chain released.
- autoconfig_cycle = (ADDR[23:16]==8'hE8) && cfgin && state==PRESENT && !AS_n.
- Access: when UDS_n=0 && autoconfig_cycle && !dtack, then on the next edge dtack=1 and the action below takes place (latency 1 CLK). dtack clears on the first edge with AS_n=1. One action per bus cycle.
- Read map on ADDR[8:1]; all fields except 0x00/0x01 are inverted:
  - 00 = {3'b110, rom};
  - 01 = {1'b0, size[cur]};
  - 02/03 = product ID nibbles;
  - 04/05 = ~0;
  - 08..0B = MFG_ID nibbles;
  - 0C..13 = SERIAL nibbles;
  - 14..17 = ROM_VECTOR nibbles;
  - 20/21 = 0;
  - all others = 4'hF.
- Writes:
  - 25: pending_lo <= DIN.
  - 24: board_base[cur] <= {DIN, pending_lo}, board_configured[cur] <= 1, and set the advance flag.
  - 26 (shutup): board_configured[cur] stays 0; set the advance flag.
- Advance: at the next eoc, cur moves to the next enabled board above cur; if none remains, go to DONE. Advance and the cfgin update at the same eoc are both applied.
- CFGOUT_n = !(state==DONE). It is updated only on state change, never mid-cycle.
- board_hit[k] = board_configured[k] && (ADDR[23:16] & mask[k]) == (board_base[k] & mask[k]).
  - mask = 8'hFF << (size-1), so 64K gives FF and 4M gives C0.
  - Hits are independent. Overlap is the software's problem.
- board_enable is sampled only when choosing the next board. A change while a board is in PRESENT takes effect at the next selection.
- CFGIN_n deasserted while in PRESENT: cfgin drops at eoc, autoconfig_cycle goes low and state is held. Resume when cfgin returns.

Optional Feature:
- AUTOCONFIG_ROM_EN
- Defined:
  - board 0 reports the rom bit = 1;
  - 0x14..0x17 return ~ROM_VECTOR nibbles for board 0;
  - output rom_hit = board_hit[0] && ADDR[15:1] < 15'h4000 (first 32K).
- Undefined:
  - rom = 0 for all boards;
  - 0x14..0x17 read 4'hF;
  - rom_hit is absent.

Test Plan:
- Reset with CFGIN_n=1 and a read at E80000 -> no dtack, CFGOUT_n=1, autoconfig_cycle=0.
- CFGIN_n=0, one eoc, read 0x02 then 0x01 -> DOUT=~4'h0 then 4'b0010, with dtack 1 CLK after UDS_n falls.
- Write 0x25=4'h9 then 0x24=4'hE -> board_base[0]=E9, board_configured[0]=1. After eoc, a read of 0x03 returns ~7 (board 1). Write board 1 base EA -> after eoc CFGOUT_n=0.
- board_enable=2'b10 -> the first read of 0x03 returns ~7. Configuring board 1 releases the chain. board_configured[0] stays 0.
- Shutup write 0x26 on board 0 -> board_configured[0]=0, board 1 presented next. With board 1 configured at EA (128K), ADDR[23:16]=EB -> board_hit[1]=1 and board_hit[0]=0.
- RESET pulse mid-read with AS_n=0 -> dtack=0, state back to WAIT_CFG, all bases 0, CFGOUT_n=1.
